// File: rtl/reg_array_load_sched.sv
// Read-address sequencer that fills the reg_array FIFO with 3x3 windows of a P x P picture,
// sending a full 9-word window at the start of each window row and 3 new words per slide.
module reg_array_load_sched #(
  parameter int AW = 12
) (
  input  logic          SYS_CLK,
  input  logic          SYS_RST,
  input  logic          START,
  input  logic [7:0]    PIC_SIZE,
  input  logic [AW-1:0] BASE_ADDR,
  input  logic          REG_ARRAY_FULL,
  input  logic          REC_RDATA,
  output logic [AW-1:0] RADDR,
  output logic          RADDR_VLD,
  output logic [3:0]    NUM_RDATA,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT_REC, S_NEXT, S_FIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_p;
  logic [AW-1:0] r_row_base;
  logic [7:0]    r_win_x;
  logic [7:0]    r_win_y;
  logic [3:0]    r_num;
  logic [3:0]    r_k;
  logic [1:0]    r_r;
  logic [7:0]    r_c;
  logic [AW-1:0] r_rowptr;
  logic [AW-1:0] r_raddr;
  logic          r_raddr_vld;
  logic          r_busy;
  logic          r_done;

  logic [AW-1:0] w_p_ext;
  logic          w_x_more;
  logic          w_y_more;
  logic [7:0]    w_col0;
  logic          w_last_word;
  logic          w_wrap;
  logic [AW-1:0] w_rowptr_nx;
  logic [7:0]    w_col_nx;

  // Window-position tests are done in 9 bits so that P < 3 simply reports "no window left".
  assign w_p_ext     = AW'(r_p);
  assign w_x_more    = ({1'b0, r_win_x} + 9'd3) < {1'b0, r_p};
  assign w_y_more    = ({1'b0, r_win_y} + 9'd3) < {1'b0, r_p};
  assign w_col0      = (r_win_x == 8'd0) ? 8'd0 : (r_win_x + 8'd2);
  assign w_last_word = (r_k == (r_num - 4'd1));
  assign w_wrap      = (r_r == 2'd2);
  assign w_rowptr_nx = w_wrap ? r_row_base : (r_rowptr + w_p_ext);
  assign w_col_nx    = w_wrap ? (r_c + 8'd1) : r_c;

  // State register.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a picture smaller than 3 passes through NEXT, which finds no window and ends the scan.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = (PIC_SIZE < 8'd3) ? S_NEXT : S_CHECK;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        if (!REG_ARRAY_FULL) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      S_ISSUE: begin
        if (w_last_word) begin
          w_state_nxt = S_WAIT_REC;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WAIT_REC: begin
        if (REC_RDATA) begin
          w_state_nxt = S_NEXT;
        end else begin
          w_state_nxt = S_WAIT_REC;
        end
      end
      S_NEXT: begin
        if (w_x_more || w_y_more) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Scan position and address generation; row offsets accumulate P instead of multiplying.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_p        <= 8'd0;
      r_row_base <= '0;
      r_win_x    <= 8'd0;
      r_win_y    <= 8'd0;
      r_num      <= 4'd9;
      r_k        <= 4'd0;
      r_r        <= 2'd0;
      r_c        <= 8'd0;
      r_rowptr   <= '0;
      r_raddr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_p        <= PIC_SIZE;
            r_row_base <= BASE_ADDR;
            r_win_x    <= 8'd0;
            r_win_y    <= 8'd0;
          end
        end
        S_CHECK: begin
          if (!REG_ARRAY_FULL) begin
            r_k      <= 4'd0;
            r_r      <= 2'd0;
            r_c      <= w_col0;
            r_rowptr <= r_row_base;
            r_raddr  <= r_row_base + AW'(w_col0);
          end
        end
        S_ISSUE: begin
          if (!w_last_word) begin
            r_k      <= r_k + 4'd1;
            r_r      <= w_wrap ? 2'd0 : (r_r + 2'd1);
            r_c      <= w_col_nx;
            r_rowptr <= w_rowptr_nx;
            r_raddr  <= w_rowptr_nx + AW'(w_col_nx);
          end
        end
        S_NEXT: begin
          if (w_x_more) begin
            r_win_x <= r_win_x + 8'd1;
            r_num   <= 4'd3;
          end else if (w_y_more) begin
            r_win_x    <= 8'd0;
            r_win_y    <= r_win_y + 8'd1;
            r_row_base <= r_row_base + w_p_ext;
            r_num      <= 4'd9;
          end else begin
            r_win_x <= 8'd0;
            r_num   <= 4'd9;
          end
        end
        default: begin
          r_k <= r_k;
        end
      endcase
    end
  end

  // Status outputs registered from the upcoming state so they align with that state.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_raddr_vld <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_raddr_vld <= (w_state_nxt == S_ISSUE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_FIN);
    end
  end

  assign RADDR     = r_raddr;
  assign RADDR_VLD = r_raddr_vld;
  assign NUM_RDATA = r_num;
  assign BUSY      = r_busy;
  assign DONE      = r_done;

endmodule

// File: tb/tb_reg_array_load_sched.sv
// Directed bench for reg_array_load_sched: hand-computed address sequences, window counts,
// stall, small-picture, mid-scan reset, address wrap and spurious START/REC_RDATA cases.
module tb_reg_array_load_sched;

  logic        SYS_CLK = 1'b0;
  logic        SYS_RST = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  PIC_SIZE = 8'd0;
  logic [11:0] BASE_ADDR = 12'h000;
  logic        REG_ARRAY_FULL = 1'b0;
  logic        REC_RDATA = 1'b0;
  logic [11:0] RADDR;
  logic        RADDR_VLD;
  logic [3:0]  NUM_RDATA;
  logic        BUSY;
  logic        DONE;

  reg_array_load_sched #(.AW(12)) dut (
    .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .START(START), .PIC_SIZE(PIC_SIZE),
    .BASE_ADDR(BASE_ADDR), .REG_ARRAY_FULL(REG_ARRAY_FULL), .REC_RDATA(REC_RDATA),
    .RADDR(RADDR), .RADDR_VLD(RADDR_VLD), .NUM_RDATA(NUM_RDATA), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int cyc = 0;
  always @(posedge SYS_CLK) cyc <= cyc + 1;

  int          n_err = 0;
  int          n_chk = 0;
  logic [11:0] q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          first_vld_cyc = 0;
  int          g_nwin = 0;
  int          g_rec_cyc = 0;
  logic [3:0]  g_nums[$];

  logic [11:0] exp_p4 [24] = '{12'h100, 12'h104, 12'h108, 12'h101, 12'h105, 12'h109,
                               12'h102, 12'h106, 12'h10A, 12'h103, 12'h107, 12'h10B,
                               12'h104, 12'h108, 12'h10C, 12'h105, 12'h109, 12'h10D,
                               12'h106, 12'h10A, 12'h10E, 12'h107, 12'h10B, 12'h10F};
  logic [11:0] exp_wrap [9] = '{12'hFFE, 12'h001, 12'h004, 12'hFFF, 12'h002, 12'h005,
                                12'h000, 12'h003, 12'h006};
  logic [3:0]  exp_nums [4] = '{4'd9, 4'd3, 4'd9, 4'd3};

  // Observe reads and DONE pulses on the falling edge.
  always @(negedge SYS_CLK) begin
    if (RADDR_VLD === 1'b1) begin
      if (q.size() == 0) first_vld_cyc = cyc;
      q.push_back(RADDR);
    end
    if (DONE === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic clear_mon();
    q.delete();
    done_cnt = 0;
    done_cyc = 0;
    first_vld_cyc = 0;
  endtask

  task automatic start_scan(input logic [7:0] p, input logic [11:0] base);
    PIC_SIZE  = p;
    BASE_ADDR = base;
    START     = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Answers each window with REC_RDATA two cycles after its reads end; optional noise pulses.
  task automatic run_scan(input int stop_win, input bit noise);
    int delay;
    bit vprev;
    bit done_seen;
    delay = -1;
    vprev = 1'b0;
    done_seen = 1'b0;
    g_nwin = 0;
    g_nums.delete();
    for (int i = 0; i < 3000; i++) begin
      step();
      START = 1'b0;
      REC_RDATA = 1'b0;
      if (delay == 0) begin
        REC_RDATA = 1'b1;
        g_rec_cyc = cyc;
        delay = -1;
      end else if (delay > 0) begin
        delay = delay - 1;
      end
      if (RADDR_VLD && !vprev) begin
        g_nwin = g_nwin + 1;
        g_nums.push_back(NUM_RDATA);
        if (g_nwin == stop_win) return;
        if (noise) begin
          REC_RDATA = 1'b1;
          START = 1'b1;
          PIC_SIZE = 8'd7;
          BASE_ADDR = 12'h555;
        end
      end
      if (!RADDR_VLD && vprev) delay = 1;
      vprev = RADDR_VLD;
      if (DONE) done_seen = 1'b1;
      if (done_seen && !BUSY) return;
    end
    chk("scan_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bad;
    int qs;
    int drop_cyc;

    // Reset state
    step();
    step();
    chk("rst_raddr", 32'(RADDR), 32'h000);
    chk("rst_vld", 32'(RADDR_VLD), 32'd0);
    chk("rst_num", 32'(NUM_RDATA), 32'd9);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    SYS_RST = 1'b0;
    step();

    // P=4 clean run
    clear_mon();
    start_scan(8'd4, 12'h100);
    chk("p4_busy_start", 32'(BUSY), 32'd1);
    run_scan(0, 1'b0);
    chk("p4_nreads", 32'(q.size()), 32'd24);
    for (int i = 0; i < 24; i++) chk($sformatf("p4_addr%0d", i), 32'(q[i]), 32'(exp_p4[i]));
    chk("p4_nwin", 32'(g_nwin), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("p4_num%0d", i), 32'(g_nums[i]), 32'(exp_nums[i]));
    chk("p4_done_cnt", 32'(done_cnt), 32'd1);
    chk("p4_done_cyc", 32'(done_cyc), 32'(g_rec_cyc + 2));
    chk("p4_idle_busy", 32'(BUSY), 32'd0);

    // FULL held for 10 cycles after START
    clear_mon();
    REG_ARRAY_FULL = 1'b1;
    start_scan(8'd4, 12'h100);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(BUSY === 1'b1 && RADDR_VLD === 1'b0)) bad = bad + 1;
      step();
    end
    chk("full_hold", 32'(bad), 32'd0);
    chk("full_no_reads", 32'(q.size()), 32'd0);
    REG_ARRAY_FULL = 1'b0;
    drop_cyc = cyc;
    run_scan(0, 1'b0);
    chk("full_first_addr", 32'(q[0]), 32'h100);
    chk("full_first_cyc", 32'(first_vld_cyc), 32'(drop_cyc + 1));
    chk("full_nreads", 32'(q.size()), 32'd24);

    // P=2: no reads, DONE two cycles after START
    clear_mon();
    start_scan(8'd2, 12'h100);
    chk("p2_busy1", 32'(BUSY), 32'd1);
    chk("p2_done1", 32'(DONE), 32'd0);
    step();
    chk("p2_busy2", 32'(BUSY), 32'd1);
    chk("p2_done2", 32'(DONE), 32'd1);
    step();
    chk("p2_busy3", 32'(BUSY), 32'd0);
    chk("p2_done3", 32'(DONE), 32'd0);
    chk("p2_reads", 32'(q.size()), 32'd0);

    // P=5 reset during the second window's reads, then a fresh scan
    clear_mon();
    start_scan(8'd5, 12'h200);
    run_scan(2, 1'b0);
    chk("rst5_in_issue", 32'(RADDR_VLD), 32'd1);
    SYS_RST = 1'b1;
    step();
    SYS_RST = 1'b0;
    chk("rst5_vld", 32'(RADDR_VLD), 32'd0);
    chk("rst5_busy", 32'(BUSY), 32'd0);
    chk("rst5_num", 32'(NUM_RDATA), 32'd9);
    qs = q.size();
    for (int i = 0; i < 5; i++) step();
    chk("rst5_no_reads", 32'(q.size()), 32'(qs));
    clear_mon();
    start_scan(8'd5, 12'h200);
    run_scan(0, 1'b0);
    chk("p5_first", 32'(q[0]), 32'h200);
    chk("p5_nreads", 32'(q.size()), 32'd45);
    chk("p5_last", 32'(q[44]), 32'h218);
    chk("p5_nwin", 32'(g_nwin), 32'd9);
    chk("p5_done_cnt", 32'(done_cnt), 32'd1);

    // Address wrap, P=3 at 0xFFE
    clear_mon();
    start_scan(8'd3, 12'hFFE);
    run_scan(0, 1'b0);
    chk("wrap_nreads", 32'(q.size()), 32'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("wrap_addr%0d", i), 32'(q[i]), 32'(exp_wrap[i]));
    chk("wrap_num", 32'(g_nums[0]), 32'd9);
    chk("wrap_done_cnt", 32'(done_cnt), 32'd1);

    // Spurious START / REC_RDATA / input changes mid-scan
    clear_mon();
    start_scan(8'd4, 12'h100);
    run_scan(0, 1'b1);
    chk("noise_nreads", 32'(q.size()), 32'd24);
    for (int i = 0; i < 24; i++) chk($sformatf("noise_addr%0d", i), 32'(q[i]), 32'(exp_p4[i]));
    chk("noise_nwin", 32'(g_nwin), 32'd4);
    chk("noise_done_cnt", 32'(done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
